dcache_direct_mapped: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MEM-stage load/store port and the word-addressed data memory.
- Data memory is combinational: read data is valid in the cycle its address is driven; a write takes effect while its write enable is high.
- Each 4-word block is refilled one word per cycle.
- The block raises stall to freeze the pipeline during a refill.

---
 rtl/dcache_direct_mapped.sv | 158 +++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Each line holds 4 words. A read miss refills the line one word per cycle
// from a combinational word-addressed memory, and stall is held meanwhile.
// Optional build macro: DCACHE_STATS_EN adds the hit_count and access_count outputs.
module dcache_direct_mapped #(
  parameter int INDEX_BITS = 5,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       access_count,
`endif
  input  logic [31:0]       mem_rdata
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [1:0]                r_cnt;
  logic [ADDR_W-3:0]         r_block;     // block address of the line being refilled
  logic [LINES-1:0]          r_valid;
  logic [TAG_W-1:0]          r_tag  [LINES];
  logic [31:0]               r_data [LINES*4];

  logic [INDEX_BITS-1:0]     w_index;
  logic [TAG_W-1:0]          w_tag;
  logic                      w_hit;
  logic [INDEX_BITS-1:0]     w_fill_index;
  logic [TAG_W-1:0]          w_fill_tag;
  logic                      w_idle;
  logic                      w_start_fill;
  logic                      w_fill_last;
  logic                      w_write_hit;

  assign w_index      = cpu_addr[INDEX_BITS+1:2];
  assign w_tag        = cpu_addr[ADDR_W-1:INDEX_BITS+2];
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_fill_index = r_block[INDEX_BITS-1:0];
  assign w_fill_tag   = r_block[ADDR_W-3:INDEX_BITS];
  assign w_idle       = (r_state == S_IDLE);
  // A store wins over a load presented in the same cycle.
  assign w_start_fill = !rst && w_idle && cpu_read && !cpu_write && !w_hit;
  assign w_write_hit  = !rst && w_idle && cpu_write && w_hit;
  assign w_fill_last  = !rst && (r_state == S_FILL) && (r_cnt == 2'd3);

  // Next-state and output decode; reset forces the quiet output set.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    w_next_state = r_state;
    stall        = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    cpu_rdata    = '0;
    if (rst) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_write) begin
            mem_write = 1'b1;
          end else if (cpu_read) begin
            if (w_hit) begin
              cpu_rdata = r_data[{w_index, cpu_addr[1:0]}];
            end else begin
              stall        = 1'b1;
              w_next_state = S_FILL;
            end
          end
        end
        S_FILL: begin
          stall    = 1'b1;
          mem_addr = {r_block, r_cnt};
          if (r_cnt == 2'd3) w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Fill word counter and latched block address of the refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 2'd0;
    end else if (w_start_fill) begin
      r_cnt   <= 2'd0;
      r_block <= cpu_addr[ADDR_W-1:2];
    end else if (r_state == S_FILL) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Valid bits: cleared by reset, set when the last refill word lands.
  always_ff @(posedge clk) begin
    if (rst)              r_valid <= '0;
    else if (w_fill_last) r_valid[w_fill_index] <= 1'b1;
  end

  // Tag and data arrays: refill words and store-hit updates.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are not reset; clearing valid alone makes their contents unreachable.
    if (!rst && r_state == S_FILL) begin
      r_data[{w_fill_index, r_cnt}] <= mem_rdata;
      if (r_cnt == 2'd3) r_tag[w_fill_index] <= w_fill_tag;
    end else if (w_write_hit) begin
      r_data[{w_index, cpu_addr[1:0]}] <= cpu_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_retry;   // the cycle right after a refill is the retry, not a new access
  logic [31:0] r_hit_count;
  logic [31:0] r_access_count;
  logic        w_accept;

  assign w_accept     = w_idle && !r_retry && (cpu_read || cpu_write);
  assign hit_count    = r_hit_count;
  assign access_count = r_access_count;

  // Access and hit counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retry        <= 1'b0;
      r_hit_count    <= '0;
      r_access_count <= '0;
    end else begin
      r_retry <= w_fill_last;
      if (w_accept) begin
        r_access_count <= r_access_count + 32'd1;
        if (w_hit) r_hit_count <= r_hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Self-checking bench for dcache_direct_mapped: directed scenarios followed by
// randomized loads and stores. Expected data and miss timing come from a line
// model (valid and tag per index) and a reference copy of memory.
module tb_dcache_direct_mapped;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, access_count;
`endif

  dcache_direct_mapped dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
`ifdef DCACHE_STATS_EN
    .hit_count(hit_count), .access_count(access_count),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Backing data memory: combinational read, write at the clock edge.
  logic [31:0] mem [1024];
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;

  // Reference model: expected memory contents plus per-line valid and tag.
  logic [31:0] ref_mem [1024];
  bit          m_valid [32];
  int          m_tag   [32];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
  endtask

  // Load: entered just after a posedge, leaves just after a posedge.
  task automatic do_read(input logic [31:0] a);
    int   n;
    int   idx;
    int   tg;
    bit   hit;
    logic [31:0] base;
    idx  = (a / 4) % 32;
    tg   = a / 128;
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    base = (a / 4) * 4;
    cpu_addr  = a;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 20) begin
      if (n >= 1 && n <= 4) check("fill_addr", mem_addr, base + 32'(n - 1));
      if (n >= 1) check("fill_mem_write", {31'd0, mem_write}, 32'd0);
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 32'(n), hit ? 32'd0 : 32'd5);
    check("read_data", cpu_rdata, ref_mem[a[9:0]]);
    check("read_mem_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1;
    cpu_read = 1'b0;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
  endtask

  // Store (optionally with a load asserted too): one cycle, never stalls.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit with_read);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = 1'b1;
    cpu_read  = with_read;
    @(negedge clk);
    check("write_stall", {31'd0, stall}, 32'd0);
    check("write_mem_write", {31'd0, mem_write}, 32'd1);
    check("write_mem_addr", mem_addr, a);
    check("write_mem_wdata", mem_wdata, d);
    check("write_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
    ref_mem[a[9:0]] = d;
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_mem_write", {31'd0, mem_write}, 32'd0);
    check("idle_rdata", cpu_rdata, 32'd0);
    check("idle_mem_addr", mem_addr, cpu_addr);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end
    mem[0] = 32'd1;  ref_mem[0] = 32'd1;
    mem[4] = 32'hFFFF_FFFE;  ref_mem[4] = 32'hFFFF_FFFE;
    mem[8] = 32'd4;  ref_mem[8] = 32'd4;
    clear_model();

    // Reset with a load pending: outputs must stay quiet.
    rst = 1'b1; cpu_addr = 32'd5; cpu_wdata = '0; cpu_read = 1'b1; cpu_write = 1'b0;
    @(negedge clk);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_mem_write", {31'd0, mem_write}, 32'd0);
    check("reset_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_read = 1'b0;

    // 1..2: cold miss on 5, then same-block hit on 4.
    do_read(32'd5);
    do_read(32'd4);
    idle_check();

    // 3: store hit on 6, read it back.
    do_write(32'd6, 32'd99, 1'b0);
    do_read(32'd6);

    // 4: conflict miss on 132 evicts block 4, then 4 misses again.
    do_read(32'd132);
    do_read(32'd4);

    // 5: store miss does not allocate; the following load misses.
    do_write(32'd200, 32'd7, 1'b0);
    do_read(32'd200);

    // Store and load together: the store takes priority.
    do_write(32'd201, 32'h1234_5678, 1'b1);
    do_read(32'd201);

    // Randomized loads and stores against the model.
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 9) < 3) do_write(a, $urandom, 1'b0);
      else                          do_read(a);
    end
    idle_check();

    // 6: reset in the 2nd fill cycle discards the partial line.
    cpu_addr = 32'd9; cpu_read = 1'b1;
    @(negedge clk);
    check("rst_fill_miss_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    check("rst_fill_first_addr", mem_addr, 32'd8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_fill_stall_in_reset", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_read = 1'b0;
    clear_model();
    @(negedge clk);
    check("rst_fill_idle_stall", {31'd0, stall}, 32'd0);
    check("rst_fill_idle_mem_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1;
    do_read(32'd9);
`ifdef DCACHE_STATS_EN
    check("stats_hit_count", hit_count, 32'd0);
    check("stats_access_count", access_count, 32'd1);
`endif
    do_read(32'd10);
`ifdef DCACHE_STATS_EN
    check("stats_hit_count_2", hit_count, 32'd1);
    check("stats_access_count_2", access_count, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
